// File: rtl/stereo_line_scheduler.sv
// Per-line read sequencer for the stereo matcher line buffers: latches the completed
// buffer, derives WIN row selects, sweeps the column address and flags full windows.
module stereo_line_scheduler #(
  parameter int COL_FIRST  = 2,
  parameter int COL_LAST   = 641,
  parameter int WIN        = 5,
  parameter int NBUF       = 6,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 10
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic              read_start,
  input  logic [2:0]        select_ps,
  input  logic              enable,
  input  logic              clr_overrun,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3*WIN-1:0]  rd_row_sel,
  output logic              win_valid,
  output logic [ADDR_W-1:0] win_col,
  output logic              line_done,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr_nxt;
  logic [3*WIN-1:0]    r_row_sel, w_row_sel_nxt;
  logic                r_line_done, w_line_done_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic                r_pending, w_pending_nxt;
  logic [2:0]          r_pending_sel, w_pending_sel_nxt;
  logic [ADDR_W-1:0]   r_drain_cnt, w_drain_nxt;
  logic                w_req, w_start, w_overrun_set;
  logic [2:0]          w_start_sel;
  logic [3:0]          w_sum;
  logic                w_win_in;
  logic [ADDR_W-1:0]   w_col_in;
  logic [RD_LATENCY-1:0] r_vpipe;
  logic [ADDR_W-1:0]   r_cpipe [RD_LATENCY];

  assign w_req = read_start & enable;

  always_comb begin
    w_state_nxt       = r_state;
    w_rd_en_nxt       = r_rd_en;
    w_rd_addr_nxt     = r_rd_addr;
    w_row_sel_nxt     = r_row_sel;
    w_line_done_nxt   = 1'b0;
    w_pending_nxt     = r_pending;
    w_pending_sel_nxt = r_pending_sel;
    w_drain_nxt       = r_drain_cnt;
    w_overrun_set     = 1'b0;
    w_start           = 1'b0;
    w_start_sel       = select_ps;
    w_sum             = '0;

    // Requests arriving during a sweep fill the single pending slot or are dropped.
    if (r_state != S_IDLE && w_req) begin
      if (!r_pending) begin
        w_pending_nxt     = 1'b1;
        w_pending_sel_nxt = select_ps;
      end else begin
        w_overrun_set = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_start       = 1'b1;
          w_start_sel   = r_pending_sel;
          w_pending_nxt = w_req;
          if (w_req) w_pending_sel_nxt = select_ps;
        end else if (w_req) begin
          w_start = 1'b1;
        end
      end
      S_SWEEP: begin
        // One trailing cycle with rd_en low before draining the read pipeline.
        if (r_rd_en) begin
          if (r_rd_addr == ADDR_W'(COL_LAST)) begin
            w_rd_en_nxt   = 1'b0;
            w_rd_addr_nxt = ADDR_W'(COL_FIRST);
          end else begin
            w_rd_addr_nxt = r_rd_addr + 1'b1;
          end
        end else begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = ADDR_W'(RD_LATENCY - 1);
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt     = S_DONE;
          w_line_done_nxt = 1'b1;
        end else begin
          w_drain_nxt = r_drain_cnt - 1'b1;
        end
      end
      S_DONE: begin
        if (r_pending) begin
          w_start       = 1'b1;
          w_start_sel   = r_pending_sel;
          w_pending_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_start) begin
      w_state_nxt   = S_SWEEP;
      w_rd_en_nxt   = 1'b1;
      w_rd_addr_nxt = ADDR_W'(COL_FIRST);
      for (int k = 0; k < WIN; k++) begin
        w_sum = 4'(w_start_sel) + 4'(NBUF - WIN + 1 + k);
        w_row_sel_nxt[3*k +: 3] = 3'(w_sum % 4'(NBUF));
      end
    end

    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_overrun_nxt = w_overrun_set ? 1'b1 : (clr_overrun ? 1'b0 : r_overrun);
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= ADDR_W'(COL_FIRST);
      r_row_sel     <= '0;
      r_line_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_pending     <= 1'b0;
      r_pending_sel <= '0;
      r_drain_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_en       <= w_rd_en_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_row_sel     <= w_row_sel_nxt;
      r_line_done   <= w_line_done_nxt;
      r_busy        <= w_busy_nxt;
      r_overrun     <= w_overrun_nxt;
      r_pending     <= w_pending_nxt;
      r_pending_sel <= w_pending_sel_nxt;
      r_drain_cnt   <= w_drain_nxt;
    end
  end

  // A window is complete once WIN columns have been read; report its centre column.
  assign w_win_in = r_rd_en && (r_rd_addr >= ADDR_W'(COL_FIRST + WIN - 1));
  assign w_col_in = r_rd_addr - ADDR_W'((WIN - 1) / 2);

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vpipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_cpipe[i] <= '0;
    end else begin
      r_vpipe[0] <= w_win_in;
      if (w_win_in) r_cpipe[0] <= w_col_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        if (r_vpipe[i-1]) r_cpipe[i] <= r_cpipe[i-1];
      end
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign rd_row_sel = r_row_sel;
  assign win_valid  = r_vpipe[RD_LATENCY-1];
  assign win_col    = r_cpipe[RD_LATENCY-1];
  assign line_done  = r_line_done;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule
